// File: rtl/ppm_rx_param.sv
// Parametrised 1-of-2^B PPM frame receiver: SOF/EOF framing, symbol decode,
// invalid-symbol flagging and maximum frame length enforcement.
module ppm_rx_param #(
  parameter int         B            = 2,
  parameter logic [7:0] SOF_PAT      = 8'b0111_1011,
  parameter logic [7:0] EOF_PAT      = 8'b1101_0001,
  parameter int         MAX_SYMS     = 255,
  parameter int         CNT_W        = 8,
  parameter bit         ABORT_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [B-1:0]     sym_data,
  output logic             sym_valid,
  output logic             sym_err,
  output logic             sof,
  output logic             eof,
  output logic             frame_err,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             busy
);

  localparam int N     = 2 ** (B + 1);
  localparam int CW    = B + 1;
  localparam int NSLOT = 2 ** B;

  typedef enum logic {IDLE, DATA} state_t;

  state_t          state;
  logic [7:0]      hist;
  logic [N-2:0]    symsr;
  logic [CW-1:0]   chip_cnt;

  logic [7:0]      win;
  logic [N-1:0]    sym;
  logic            sym_hit;
  logic [B-1:0]    sym_idx;

  assign win  = {hist[6:0], din};
  assign sym  = {symsr, din};
  assign busy = (state == DATA);

  // A legal symbol has a single 0 chip, and it must be the second chip of a slot.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
    sym_hit = 1'b0;
    sym_idx = '0;
    for (int j = 0; j < NSLOT; j++) begin
      if (sym == ~(N'(1) << (N - 2 - 2 * j))) begin
        sym_hit = 1'b1;
        sym_idx = B'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hist      <= '0;
      symsr     <= '0;
      chip_cnt  <= '0;
      sym_data  <= '0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_err <= 1'b0;
      sym_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      sof       <= 1'b0;
      eof       <= 1'b0;
      sym_valid <= 1'b0;
      sym_err   <= 1'b0;
      frame_err <= 1'b0;
      sym_data  <= '0;
      hist      <= win;
      case (state)
        IDLE: begin
          if (win == SOF_PAT) begin
            state    <= DATA;
            chip_cnt <= '0;
            sym_cnt  <= '0;
            symsr    <= '0;
            sof      <= 1'b1;
          end
        end
        DATA: begin
          symsr <= sym[N-2:0];
          // EOF is only recognised as the first 8 chips of a symbol period.
          if (chip_cnt == CW'(7) && win == EOF_PAT) begin
            eof      <= 1'b1;
            state    <= IDLE;
            chip_cnt <= '0;
          end else if (chip_cnt == CW'(N - 1)) begin
            chip_cnt <= '0;
            if (!sym_hit) begin
              sym_err <= 1'b1;
              if (ABORT_ON_ERR) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else if (sym_cnt == CNT_W'(MAX_SYMS)) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              sym_valid <= 1'b1;
              sym_data  <= sym_idx;
              sym_cnt   <= sym_cnt + CNT_W'(1);
            end
          end else begin
            chip_cnt <= chip_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_rx_param.sv
// Table-driven bench for ppm_rx_param: four parameter variants share one chip
// stream; each test observes the variant it targets chip by chip.
module tb_ppm_rx_param;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       sv;
    logic       se;
    logic       fe;
    logic       busy;
    logic [3:0] data;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic din;
    exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;

  logic [1:0] d0, d2, d3;
  logic [3:0] d1;
  logic       sv [4];
  logic       se [4];
  logic       sf [4];
  logic       ef [4];
  logic       fe [4];
  logic       bz [4];
  logic [7:0] cnt [4];

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  ppm_rx_param #(.B(2)) u_b2 (
    .clk(clk), .rst(rst), .din(din), .sym_data(d0), .sym_valid(sv[0]), .sym_err(se[0]),
    .sof(sf[0]), .eof(ef[0]), .frame_err(fe[0]), .sym_cnt(cnt[0]), .busy(bz[0]));

  ppm_rx_param #(.B(4)) u_b4 (
    .clk(clk), .rst(rst), .din(din), .sym_data(d1), .sym_valid(sv[1]), .sym_err(se[1]),
    .sof(sf[1]), .eof(ef[1]), .frame_err(fe[1]), .sym_cnt(cnt[1]), .busy(bz[1]));

  ppm_rx_param #(.B(2), .ABORT_ON_ERR(1'b1)) u_abort (
    .clk(clk), .rst(rst), .din(din), .sym_data(d2), .sym_valid(sv[2]), .sym_err(se[2]),
    .sof(sf[2]), .eof(ef[2]), .frame_err(fe[2]), .sym_cnt(cnt[2]), .busy(bz[2]));

  ppm_rx_param #(.B(2), .MAX_SYMS(3)) u_max3 (
    .clk(clk), .rst(rst), .din(din), .sym_data(d3), .sym_valid(sv[3]), .sym_err(se[3]),
    .sof(sf[3]), .eof(ef[3]), .frame_err(fe[3]), .sym_cnt(cnt[3]), .busy(bz[3]));

  function automatic exp_t mk(input logic sof_e, input logic eof_e, input logic sv_e,
                              input logic se_e, input logic fe_e, input logic busy_e,
                              input logic [3:0] data_e, input logic [7:0] cnt_e);
    exp_t e;
    e.sof  = sof_e;
    e.eof  = eof_e;
    e.sv   = sv_e;
    e.se   = se_e;
    e.fe   = fe_e;
    e.busy = busy_e;
    e.data = data_e;
    e.cnt  = cnt_e;
    return e;
  endfunction

  function automatic exp_t obs(input int s);
    logic [3:0] d;
    case (s)
      0:       d = 4'(d0);
      1:       d = d1;
      2:       d = 4'(d2);
      default: d = 4'(d3);
    endcase
    return mk(sf[s], ef[s], sv[s], se[s], fe[s], bz[s], d, cnt[s]);
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: got {sof,eof,sv,se,fe,busy,data,cnt}=%h required %h", name, act, req);
    else
      n_pass++;
  endtask

  // Queue len chips (earliest chip in the MSB of the used field); all but the
  // last chip expect quiet pulses with the given busy/count.
  task automatic seg(input logic [31:0] chips, input int len, input logic busy_mid,
                     input logic [7:0] cnt_mid, input exp_t last);
    vec_t v;
    for (int k = 0; k < len; k++) begin
      v.din = chips[len-1-k];
      v.exp = (k == len - 1) ? last : mk(0, 0, 0, 0, 0, busy_mid, 4'd0, cnt_mid);
      q.push_back(v);
    end
  endtask

  task automatic run(input string name, input int sel);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      din = q[i].din;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, i), obs(sel), q[i].exp);
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    din = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lead_in(input logic [7:0] cnt_e);
    seg(32'hFF, 8, 1'b0, cnt_e, mk(0, 0, 0, 0, 0, 0, 4'd0, cnt_e));
    seg(32'h7B, 8, 1'b0, cnt_e, mk(1, 0, 0, 0, 0, 1, 4'd0, 8'd0));
  endtask

  initial begin
    // Reset state of every variant.
    do_reset();
    for (int s = 0; s < 4; s++) check($sformatf("reset_%0d", s), obs(s), '0);

    // B=2 basic frame: symbols 0..3, then EOF and idle.
    lead_in(8'd0);
    seg(32'hBF, 8, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 1, 4'd0, 8'd1));
    seg(32'hEF, 8, 1'b1, 8'd1, mk(0, 0, 1, 0, 0, 1, 4'd1, 8'd2));
    seg(32'hFB, 8, 1'b1, 8'd2, mk(0, 0, 1, 0, 0, 1, 4'd2, 8'd3));
    seg(32'hFE, 8, 1'b1, 8'd3, mk(0, 0, 1, 0, 0, 1, 4'd3, 8'd4));
    seg(32'hD1, 8, 1'b1, 8'd4, mk(0, 1, 0, 0, 0, 0, 4'd0, 8'd4));
    seg(32'hFF, 8, 1'b0, 8'd4, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd4));
    run("basic", 0);

    // B=4: 32-chip symbol with the pulse in slot 9, then EOF inside a period.
    do_reset();
    lead_in(8'd0);
    seg(32'hFFFF_EFFF, 32, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 1, 4'd9, 8'd1));
    seg(32'hD1, 8, 1'b1, 8'd1, mk(0, 1, 0, 0, 0, 0, 4'd0, 8'd1));
    seg(32'hFF_FFFF, 24, 1'b0, 8'd1, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd1));
    run("b4", 1);

    // Invalid symbol, frame continues.
    do_reset();
    lead_in(8'd0);
    seg(32'hAF, 8, 1'b1, 8'd0, mk(0, 0, 0, 1, 0, 1, 4'd0, 8'd0));
    seg(32'hFE, 8, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 1, 4'd3, 8'd1));
    seg(32'hD1, 8, 1'b1, 8'd1, mk(0, 1, 0, 0, 0, 0, 4'd0, 8'd1));
    run("err_cont", 0);

    // Invalid symbol aborts the frame.
    do_reset();
    lead_in(8'd0);
    seg(32'hAF, 8, 1'b1, 8'd0, mk(0, 0, 0, 1, 1, 0, 4'd0, 8'd0));
    seg(32'hFE, 8, 1'b0, 8'd0, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd0));
    seg(32'hD1, 8, 1'b0, 8'd0, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd0));
    run("err_abort", 2);

    // Length overrun with MAX_SYMS=3.
    do_reset();
    lead_in(8'd0);
    seg(32'hFB, 8, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 1, 4'd2, 8'd1));
    seg(32'hFB, 8, 1'b1, 8'd1, mk(0, 0, 1, 0, 0, 1, 4'd2, 8'd2));
    seg(32'hFB, 8, 1'b1, 8'd2, mk(0, 0, 1, 0, 0, 1, 4'd2, 8'd3));
    seg(32'hFB, 8, 1'b1, 8'd3, mk(0, 0, 0, 0, 1, 0, 4'd0, 8'd3));
    seg(32'hFB, 8, 1'b0, 8'd3, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd3));
    run("max3", 3);

    // Asynchronous reset after chip 4 of a symbol, then a fresh frame.
    do_reset();
    lead_in(8'd0);
    seg(32'hB, 4, 1'b1, 8'd0, mk(0, 0, 0, 0, 0, 1, 4'd0, 8'd0));
    run("pre_rst", 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", obs(0), '0);
    @(negedge clk);
    rst = 1'b0;
    seg(32'hF, 4, 1'b0, 8'd0, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd0));
    seg(32'hFB, 8, 1'b0, 8'd0, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'd0));
    seg(32'h7B, 8, 1'b0, 8'd0, mk(1, 0, 0, 0, 0, 1, 4'd0, 8'd0));
    seg(32'hEF, 8, 1'b1, 8'd0, mk(0, 0, 1, 0, 0, 1, 4'd1, 8'd1));
    seg(32'hD1, 8, 1'b1, 8'd1, mk(0, 1, 0, 0, 0, 0, 4'd0, 8'd1));
    run("post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppm_rx_param.md
Name: ppm_rx_param

Overview:
Parametrised pulse-position-modulation frame receiver. It is the successor to the fixed 1-of-4 chip decoder.
- Supports 1-of-2^B PPM symbols, with B set by a parameter.
- SOF and EOF patterns are programmable.
- Flags invalid symbols and can optionally abort the frame on error.
- Enforces a maximum frame length and reports a per-frame symbol count.
- Sits between the chip sampler (one chip per clk) and the byte/frame assembler.

Parameters:
- B, 2, bits per symbol. Legal range 2..4. A symbol is N = 2^(B+1) chips.
- SOF_PAT, 8'b0111_1011, start-of-frame chip pattern. MSB is the earliest chip.
- EOF_PAT, 8'b1101_0001, end-of-frame chip pattern. MSB is the earliest chip.
- MAX_SYMS, 255, maximum valid symbols per frame before a forced abort.
- CNT_W, 8, width of sym_cnt. Requires MAX_SYMS <= 2^CNT_W-1.
- ABORT_ON_ERR, 0, 1 = an invalid symbol terminates the frame.

Ports:
- clk  in  1  clock. One chip is sampled per rising edge.
- rst  in  1  asynchronous reset, active-high.
- din  in  1  chip input. Idle level is 1; a pulse is a 0 chip.
- sym_data  out  B  decoded symbol value. Valid only with sym_valid; otherwise 0.
- sym_valid  out  1  one-cycle pulse: a valid symbol was decoded.
- sym_err  out  1  one-cycle pulse: the symbol period held no valid pulse pattern.
- sof  out  1  one-cycle pulse: SOF detected.
- eof  out  1  one-cycle pulse: EOF detected, normal frame end.
- frame_err  out  1  one-cycle pulse: frame aborted by error or length overrun.
- sym_cnt  out  CNT_W  count of valid symbols in the current or last frame.
- busy  out  1  high while in DATA state. Combinational decode of the state register.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; history, symbol shift register and chip_cnt are all 0.
  - All outputs are 0.
  - A reset mid-frame discards the partial symbol; no pulse is emitted on release.
- Internal storage:
  - `hist`: 8-bit chip history, shifting every edge in both states.
  - `symsr`: N-1 bit symbol shift register, shifting in DATA.
  - `chip_cnt`: 0..N-1, counts chips already captured in the current symbol.
- Match window: W = {hist[6:0],din}, i.e. the last 8 chips including the one sampled at this edge. All pattern compares use W and take effect at that same edge.
- IDLE:
  - If W == SOF_PAT: go to DATA, chip_cnt <= 0, sym_cnt <= 0, and sof=1 for the next cycle.
  - The first chip after SOF is symbol chip 0.
- DATA, at each edge:
  - Capture din and increment chip_cnt.
  - S = {symsr, din} is the full symbol once chip_cnt == N-1.
- EOF check (priority 1):
  - Only when chip_cnt == 7, i.e. the first 8 chips of a symbol period.
  - If W == EOF_PAT: eof=1 and go to IDLE. No sym_valid/sym_err is emitted, even when N == 8.
- Symbol decode (priority 2), at chip_cnt == N-1:
  - Chip_cnt wraps to 0.
  - Slot j is chip pair (2j, 2j+1) in arrival order.
  - The symbol is valid iff exactly one slot reads "10" and every other chip is 1. Then sym_data = j and sym_valid = 1.
  - Otherwise sym_err = 1 and sym_data = 0.
  - Latency: the outputs are registered in the cycle immediately after the edge that sampled the last chip.
- Valid symbol accounting:
  - A valid symbol increments sym_cnt.
  - If the new value equals MAX_SYMS and no EOF is present, then in the following symbol period the first decode or EOF check applies normally.
  - A further valid symbol beyond MAX_SYMS asserts frame_err, is not emitted and is not counted, and the state goes to IDLE.
- Invalid symbol handling:
  - ABORT_ON_ERR = 1: frame_err pulses together with sym_err, and the state goes to IDLE.
  - ABORT_ON_ERR = 0: the frame continues.
- sym_cnt holds its value after the frame ends until the next SOF; it never wraps.
- SOF patterns inside DATA are ignored.
- After returning to IDLE, a new SOF may be detected from the very next edge using the existing hist contents. Back-to-back frames are legal.
- Pulses are never simultaneous except sym_err together with frame_err.

Test Plan:
- B=2 basic frame: after reset send 1111_1111, then SOF 0111_1011, then symbols 1011_1111, 1110_1111, 1111_1011, 1111_1110, then EOF 1101_0001.
  - Required: sof once; sym_valid ×4 with sym_data 0,1,2,3, each one cycle after the symbol's last chip.
  - Then eof, sym_cnt=4, busy low.
- B=4: SOF, then a 32-chip symbol with "10" at chips 18–19 and all other chips 1, then EOF (8 chips) followed by 24 chips of 1.
  - Required: sym_data=9 with sym_valid.
  - Then eof at the 8th chip of the second period; no sym_err.
- Invalid symbol, ABORT_ON_ERR=0: SOF, 1010_1111, 1111_1110, EOF.
  - Required: sym_err, then sym_valid with data 3, eof, sym_cnt=1.
- The same stimulus with ABORT_ON_ERR=1.
  - Required: sym_err and frame_err in the same cycle; busy drops; no further sym_valid; no eof.
- MAX_SYMS=3: SOF followed by 5 valid symbols of 1111_1011 and no EOF.
  - Required: sym_valid ×3 with sym_cnt=3, then frame_err on the 4th symbol and IDLE. The 5th symbol is ignored.
- Reset mid-symbol: assert rst after chip 4 of a symbol inside a frame.
  - Required: all outputs 0 immediately and busy=0.
  - After release, data chips produce nothing until a fresh SOF, and then the frame decodes normally.
